// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I funct3
// encodings, response error causes and the control FSM state.
package lsu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Response error causes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: request legality checks, store strobe and
// data replication, and load byte/half extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [1:0]  err
);

    logic illegal;
    logic misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Legality: illegal funct3 takes priority over misalignment
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_store) begin
            illegal = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end else begin
            illegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                        funct3 == F3_LBU || funct3 == F3_LHU);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (illegal) begin
            err = ERR_ILLEGAL;
        end else if (misaligned) begin
            err = ERR_MISALIGN;
        end else begin
            err = ERR_NONE;
        end
    end

    // Store lane strobes and data replicated across every lane
    always_comb begin
        wstrb = 4'b1111;
        wdata = st_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        ld_byte = 8'h00;
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        case (funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_data = ld_word;
            F3_LBU:  ld_data = {24'h0, ld_byte};
            F3_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store at a time, drives a
// single-outstanding request/ready memory port, and returns a one-cycle
// writeback response or error cause. Flush squashes without aborting the bus.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_wb_en,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    output logic        stall
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    // Keep at least one counter bit so a disabled timeout still elaborates
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      err_q, err_d;
    logic [31:0]     data_q, data_d;
    logic            squash_q, squash_d;

    logic            accept;
    logic            timeout_hit;
    logic            sel_is_store;
    logic [2:0]      sel_funct3;
    logic [1:0]      sel_addr_lo;
    logic [31:0]     sel_wdata;
    logic [3:0]      al_wstrb;
    logic [31:0]     al_wdata;
    logic [31:0]     al_ld_data;
    logic [1:0]      al_err;

    assign accept      = req_valid && (state_q == ST_IDLE) && !flush;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // In IDLE the aligner checks the incoming op; otherwise it formats the latched one
    assign sel_is_store = (state_q == ST_IDLE) ? req_is_store   : is_store_q;
    assign sel_funct3   = (state_q == ST_IDLE) ? req_funct3     : funct3_q;
    assign sel_addr_lo  = (state_q == ST_IDLE) ? req_addr[1:0]  : addr_q[1:0];
    assign sel_wdata    = (state_q == ST_IDLE) ? req_wdata      : wdata_q;

    lsu_align u_align (
        .is_store (sel_is_store),
        .funct3   (sel_funct3),
        .addr_lo  (sel_addr_lo),
        .st_data  (sel_wdata),
        .ld_word  (mem_rdata),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data),
        .err      (al_err)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            err_q      <= ERR_NONE;
            data_q     <= 32'h0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            data_q     <= data_d;
            squash_q   <= squash_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        err_d      = err_q;
        data_d     = data_q;
        squash_d   = squash_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    err_d      = al_err;
                    data_d     = 32'h0;
                    cnt_d      = '0;
                    squash_d   = 1'b0;
                    state_d    = (al_err != ERR_NONE) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_ready) begin
                    err_d   = ERR_NONE;
                    data_d  = is_store_q ? 32'h0 : al_ld_data;
                    state_d = (squash_q || flush) ? ST_IDLE : ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    data_d  = 32'h0;
                    state_d = (squash_q || flush) ? ST_IDLE : ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port outputs decoded from the current state and latched op
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        stall      = (state_q != ST_IDLE) || accept;
        mem_req    = (state_q == ST_ACCESS);
        mem_we     = (state_q == ST_ACCESS) && is_store_q;
        mem_addr   = (state_q == ST_ACCESS) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wstrb  = mem_we ? al_wstrb : 4'b0000;
        mem_wdata  = mem_we ? al_wdata : 32'h0;
        resp_valid = (state_q == ST_RESP) && !flush;
        resp_wb_en = resp_valid && !is_store_q && (err_q == ERR_NONE);
        resp_rd    = resp_valid ? rd_q   : 5'd0;
        resp_data  = resp_valid ? data_q : 32'h0;
        resp_err   = resp_valid ? err_q  : ERR_NONE;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_wb_en;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    // Values captured by do_op
    int          resp_cyc;
    int          req_cycles;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_we;
    logic [31:0] r_data;
    logic [1:0]  r_err;
    logic        r_wb;
    logic [4:0]  r_rd;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_wb_en   (resp_wb_en),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op, then run up to 40 cycles: mem_ready in cycle rdy_at,
    // flush in cycle flush_at (0 = never). Cycle 1 is the first after accept.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int rdy_at,
                         input logic [31:0] rdata, input int flush_at);
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        #1;
        check("accept_ready", {31'h0, req_ready}, 32'h1);
        check("accept_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        resp_cyc   = -1;
        req_cycles = 0;
        c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0; c_we = 1'b0;
        r_data = 32'h0; r_err = 2'b00; r_wb = 1'b0; r_rd = 5'd0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            mem_ready = (cyc == rdy_at);
            mem_rdata = rdata;
            flush     = (cyc == flush_at);
            #1;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    c_addr  = mem_addr;
                    c_wdata = mem_wdata;
                    c_wstrb = mem_wstrb;
                    c_we    = mem_we;
                end
                req_cycles++;
            end
            if (resp_valid) begin
                r_data   = resp_data;
                r_err    = resp_err;
                r_wb     = resp_wb_en;
                r_rd     = resp_rd;
                resp_cyc = cyc;
                break;
            end
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
        $display("op st=%0d f3=%03b addr=%08h: mem_req_cycles=%0d resp_cyc=%0d err=%0d wb=%0d data=%08h",
                 st, f3, addr, req_cycles, resp_cyc, r_err, r_wb, r_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);

        // SW 0x100, ready 3 cycles after accept
        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 3, 32'h0, 0);
        check("sw_resp_cyc", resp_cyc, 4);
        check("sw_addr", c_addr, 32'h100);
        check("sw_wstrb", {28'h0, c_wstrb}, 32'hF);
        check("sw_wdata", c_wdata, 32'hDEADBEEF);
        check("sw_we", {31'h0, c_we}, 32'h1);
        check("sw_wb", {31'h0, r_wb}, 32'h0);
        check("sw_req_cycles", req_cycles, 3);

        // LB / LBU at byte 3
        do_op(1'b0, 3'b000, 32'h203, 32'h0, 5'd5, 1, 32'h80FF1234, 0);
        check("lb_data", r_data, 32'hFFFFFF80);
        check("lb_wb", {31'h0, r_wb}, 32'h1);
        check("lb_rd", {27'h0, r_rd}, 32'd5);
        check("lb_addr", c_addr, 32'h200);
        check("lb_we", {31'h0, c_we}, 32'h0);
        check("lb_resp_cyc", resp_cyc, 2);
        do_op(1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 1, 32'h80FF1234, 0);
        check("lbu_data", r_data, 32'h00000080);

        // Half and word loads from the same word
        do_op(1'b0, 3'b001, 32'h202, 32'h0, 5'd7, 2, 32'h80FF1234, 0);
        check("lh_data", r_data, 32'hFFFF80FF);
        do_op(1'b0, 3'b101, 32'h202, 32'h0, 5'd7, 2, 32'h80FF1234, 0);
        check("lhu_data", r_data, 32'h000080FF);
        do_op(1'b0, 3'b010, 32'h200, 32'h0, 5'd8, 1, 32'h80FF1234, 0);
        check("lw_data", r_data, 32'h80FF1234);

        // SH upper half, SB lane 1
        do_op(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd0, 1, 32'h0, 0);
        check("sh_wstrb", {28'h0, c_wstrb}, 32'hC);
        check("sh_wdata", c_wdata, 32'hABCDABCD);
        do_op(1'b1, 3'b000, 32'h101, 32'h000000A5, 5'd0, 1, 32'h0, 0);
        check("sb_wstrb", {28'h0, c_wstrb}, 32'h2);
        check("sb_wdata", c_wdata, 32'hA5A5A5A5);

        // Misaligned LH
        do_op(1'b0, 3'b001, 32'h101, 32'h0, 5'd9, 1, 32'h0, 0);
        check("lh_mis_err", {30'h0, r_err}, 32'h1);
        check("lh_mis_resp_cyc", resp_cyc, 1);
        check("lh_mis_req_cycles", req_cycles, 0);
        check("lh_mis_wb", {31'h0, r_wb}, 32'h0);

        // Illegal funct3; illegal beats misaligned
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd9, 1, 32'h0, 0);
        check("ld011_err", {30'h0, r_err}, 32'h2);
        check("ld011_req_cycles", req_cycles, 0);
        do_op(1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 1, 32'h0, 0);
        check("st100_err", {30'h0, r_err}, 32'h2);
        check("st100_req_cycles", req_cycles, 0);
        do_op(1'b1, 3'b110, 32'h101, 32'h0, 5'd0, 1, 32'h0, 0);
        check("st110_mis_err", {30'h0, r_err}, 32'h2);

        // Timeout, and ready on the expiry cycle
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd3, 0, 32'h0, 0);
        check("to_err", {30'h0, r_err}, 32'h3);
        check("to_req_cycles", req_cycles, 16);
        check("to_resp_cyc", resp_cyc, 17);
        check("to_data", r_data, 32'h0);
        check("to_wb", {31'h0, r_wb}, 32'h0);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd3, 16, 32'h12345678, 0);
        check("to_edge_err", {30'h0, r_err}, 32'h0);
        check("to_edge_data", r_data, 32'h12345678);
        check("to_edge_resp_cyc", resp_cyc, 17);

        // Flush during ACCESS: bus runs to ready, no response
        do_op(1'b1, 3'b010, 32'h500, 32'h11112222, 5'd0, 5, 32'h0, 2);
        check("flush_acc_req_cycles", req_cycles, 5);
        check("flush_acc_resp_cyc", resp_cyc, -1);
        // Flush during RESP suppresses the pulse
        do_op(1'b0, 3'b000, 32'h500, 32'h0, 5'd4, 1, 32'h0, 2);
        check("flush_resp_resp_cyc", resp_cyc, -1);

        // Flush and req_valid together: not accepted
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
        flush = 1'b1;
        #1;
        check("flush_valid_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        check("flush_valid_mem_req", {31'h0, mem_req}, 32'h0);
        check("flush_valid_ready", {31'h0, req_ready}, 32'h1);
        $display("op flush+valid same cycle: mem_req=%0d req_ready=%0d", mem_req, req_ready);

        // Reset in the middle of ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_mem_req_before", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        $display("op reset mid-access: mem_req=%0d req_ready=%0d", mem_req, req_ready);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute ALU. Consumes the ALU-computed effective address (load/store funct3 000/001/010/100/101) and the rs2 store data. Performs byte-lane alignment, drives a single-outstanding request/ready data-memory port and sign/zero-extends load data. Returns a writeback-ready result or an error cause, and stalls the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may wait for mem_ready before abort; 0 disables timeout.
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready & !flush
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  ALU result (effective address)
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
flush  in  1  squash current/incoming op (branch mispredict/trap)
mem_req  out  1  memory request, held until mem_ready or timeout
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wstrb  out  4  byte strobes
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  memory completes request this cycle
mem_rdata  in  32  read word, valid when mem_ready & !mem_we
resp_valid  out  1  one-cycle pulse: op finished
resp_wb_en  out  1  write rd (valid load, no error)
resp_rd  out  5  destination register
resp_data  out  32  extended load data; 0 for stores/errors
resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
stall  out  1  = !req_ready | (state==IDLE & accept); upstream must hold

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; counter 0. Reset mid-ACCESS drops mem_req at that edge; no response.
- States: IDLE, ACCESS, RESP.
- IDLE, accept: check alignment (LH/LHU/SH addr[0]=0; LW/SW addr[1:0]=00) and funct3 (load legal 000,001,010,100,101; store legal 000,001,010). Error -> RESP with cause, no memory access. Else latch op -> ACCESS.
- Misaligned and illegal both present: illegal (10) wins.
- ACCESS: mem_req=1, outputs stable. mem_ready -> latch formatted data -> RESP. Counter increments each non-ready cycle. Counter==TIMEOUT_CYCLES-1 with no ready -> drop mem_req, cause 11 -> RESP. Ready on expiry cycle: ready wins.
- RESP: resp_valid=1 for one cycle, resp_wb_en = load & err==00, then IDLE. Next accept no earlier than the following cycle.
- Latency: accept cycle T; mem_req from T+1; mem_ready at T+k -> resp_valid at T+k+1 (min 2 cycles). Error ops: resp_valid at T+1.
- Stores: SB wstrb=1<<addr[1:0], wdata={4{d[7:0]}}; SH wstrb=addr[1]?1100:0011, wdata={2{d[15:0]}}; SW 1111.
- Loads: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Flush: in IDLE blocks accept. In ACCESS sets sticky squash; bus transaction runs to mem_ready/timeout (never abort mid-bus). Then return to IDLE without resp_valid. In RESP suppresses resp_valid that cycle.
- flush & req_valid same cycle: not accepted.

Decomposition:
- lsu_pkg: funct3 constants (LB..LHU, SB..SW), err cause codes, state enum.
- Sub-module lsu_align (combinational): store strobe/data replication, load extraction/extension, alignment/illegal checks.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, mem_ready 3 cycles later -> mem_addr 0x100, wstrb 1111, resp_valid at accept+4, wb_en 0.
- LB addr 0x203, mem_rdata 0x80FF_1234 -> resp_data 0xFFFFFF80, wb_en 1; LBU same -> 0x00000080.
- SH addr 0x102, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD; LH addr 0x101 -> err 01, no mem_req, resp at accept+1.
- Load funct3 011 -> err 10; store funct3 100 -> err 10; no mem_req.
- TIMEOUT_CYCLES 16, mem_ready never -> mem_req 16 cycles, err 11; mem_ready on 16th cycle -> err 00.
- Flush during ACCESS -> mem_req held until ready, no resp_valid; rst mid-ACCESS -> mem_req 0 next edge, req_ready 1.
